mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 33 +++
 rtl/mem_access_ctrl_wait_cnt.sv | 39 +++
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the memory-stage blocks:
//   state_t          3-bit controller state encoding
//   LATENCY_MIN/MAX  legal range of the wait-cycle parameter
//   CNT_WIDTH        width of the wait down-counter
//   wait_load_value  value loaded into the wait counter when entering WAIT
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      ACCESS = 3'd2,
      RESP   = 3'd3,
      ERR    = 3'd4
   } state_t;

   localparam int LATENCY_MIN = 0;
   localparam int LATENCY_MAX = 7;
   localparam int CNT_WIDTH   = 3;

   // The counter is loaded with latency-1 so that WAIT lasts exactly
   // 'latency' cycles, leaving when the counter reads zero. A latency of
   // zero never enters WAIT, so the value returned for it is unused.
   function automatic logic [CNT_WIDTH-1:0] wait_load_value(input int latency);
      if (latency > 0)
         return CNT_WIDTH'(latency - 1);
      else
         return '0;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_cnt.sv
// -----------------------------------------------------------------------------
// mem_wait_cnt
// 3-bit loadable down-counter with zero flag, used to time the WAIT state.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset, clears the count
//   load        load load_value (has priority over dec)
//   load_value  value to load
//   dec         decrement by one, saturating at zero
//   zero        high while the count is zero
// -----------------------------------------------------------------------------
module mem_wait_cnt
   import mem_access_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic                 dec,
   output logic                 zero
);

   logic [CNT_WIDTH-1:0] count;

   // Count register: load wins over decrement, and decrement stops at zero
   // so a stray dec can never wrap the counter back to its maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage controller between the pipeline and a single-cycle data
// memory. Accepts one load/store at a time, inserts LATENCY wait cycles,
// performs a single one-cycle memory access, then pulses a response.
// Misaligned (odd byte address) requests are answered with an error pulse
// and never reach the memory.
// Parameters:
//   ADDR_WIDTH   byte-address width
//   LATENCY      wait cycles before each access (0..7)
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   req_valid, req_wr         request strobe, 1 = store / 0 = load
//   req_addr, req_wdata       request byte address and store data
//   req_ready                 high only in IDLE
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      load data / misalignment flag with resp_valid
//   mem_enable, mem_wr        memory strobe and write enable (ACCESS only)
//   mem_addr, mem_data_in     memory address and write data (ACCESS only)
//   mem_data_out              memory read data, sampled at the end of ACCESS
// -----------------------------------------------------------------------------
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [15:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_enable,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_data_in,
   input  logic [15:0]           mem_data_out
);

   localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = wait_load_value(LATENCY);

   generate
      if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
         $error("mem_access_ctrl: LATENCY out of range");
      end
   endgenerate

   state_t                state;
   state_t                state_next;
   logic                  accept_aligned;
   logic                  cnt_load;
   logic                  cnt_dec;
   logic                  cnt_zero;
   logic                  lat_wr;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [15:0]           lat_wdata;
   logic [15:0]           rdata_q;

   mem_wait_cnt u_wait_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (WAIT_LOAD),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   // An aligned request is taken only from IDLE; everything on req_* is
   // ignored in every other state, so a requester holding req_valid through
   // RESP is taken at the first edge after the controller is back in IDLE.
   assign accept_aligned = (state == IDLE) && req_valid && !req_addr[0];

   // State register. Reset abandons whatever is in flight; since memory
   // strobes are only driven from ACCESS, no write can escape afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus counter control. The counter is loaded on the
   // accept edge so it already holds LATENCY-1 in the first WAIT cycle.
   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_addr[0]) begin
                  state_next = ERR;
               end else if (LATENCY > 0) begin
                  state_next = WAIT;
                  cnt_load   = 1'b1;
               end else begin
                  state_next = ACCESS;
               end
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               state_next = ACCESS;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture. Only aligned requests are latched; a misaligned one
   // never touches the memory so its fields are not needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept_aligned) begin
         lat_wr    <= req_wr;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
   end

   // Read-data capture at the edge ending ACCESS. Stores capture zero so
   // the RESP cycle of a store reports zero read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (state == ACCESS) begin
         rdata_q <= lat_wr ? 16'h0000 : mem_data_out;
      end
   end

   // Output decode. Memory signals are forced to zero outside ACCESS so a
   // read and a write can never overlap and nothing leaks while idle.
   always_comb begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      resp_rdata  = 16'h0000;
      mem_enable  = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_in = 16'h0000;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
         end
         ACCESS: begin
            mem_enable  = 1'b1;
            mem_wr      = lat_wr;
            mem_addr    = lat_addr;
            mem_data_in = lat_wdata;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. One instance uses LATENCY=2 against a
// small word memory model preloaded with 16'hA000+index; a second instance
// uses LATENCY=0 against a combinational data pattern (addr ^ 16'h5A5A).
// Cycle k means the cycle after the k-th edge following the accept edge;
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;

   logic        req_valid;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        mem_enable;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;

   logic        req_valid0;
   logic        req_wr0;
   logic [15:0] req_addr0;
   logic [15:0] req_wdata0;
   logic        req_ready0;
   logic        resp_valid0;
   logic [15:0] resp_rdata0;
   logic        resp_err0;
   logic        mem_enable0;
   logic        mem_wr0;
   logic [15:0] mem_addr0;
   logic [15:0] mem_data_in0;
   logic [15:0] mem_data_out0;

   logic        mem_init;
   logic [15:0] mem_array [0:255];

   int          checks;
   int          failures;

   mem_access_ctrl #(.ADDR_WIDTH(16), .LATENCY(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_enable   (mem_enable),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   mem_access_ctrl #(.ADDR_WIDTH(16), .LATENCY(0)) dut0 (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid0),
      .req_wr       (req_wr0),
      .req_addr     (req_addr0),
      .req_wdata    (req_wdata0),
      .req_ready    (req_ready0),
      .resp_valid   (resp_valid0),
      .resp_rdata   (resp_rdata0),
      .resp_err     (resp_err0),
      .mem_enable   (mem_enable0),
      .mem_wr       (mem_wr0),
      .mem_addr     (mem_addr0),
      .mem_data_in  (mem_data_in0),
      .mem_data_out (mem_data_out0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle word memory: combinational read, write on the rising edge.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem_array[i] <= 16'hA000 + 16'(i);
         end
      end else if (mem_enable && mem_wr) begin
         mem_array[mem_addr[8:1]] <= mem_data_in;
      end
   end

   assign mem_data_out  = mem_array[mem_addr[8:1]];
   assign mem_data_out0 = mem_enable0 ? (mem_addr0 ^ 16'h5A5A) : 16'h0000;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata);
      req_valid = valid;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Aligned request on the LATENCY=2 instance: WAIT in cycles 1-2, ACCESS
   // in cycle 3, RESP in cycle 4, back in IDLE in cycle 5.
   task automatic runAligned(input string name, input logic wr,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_rdata);
      checkOutput({name, "_ready_pre"}, 32'(req_ready), 32'd1);
      applyStimulus(1'b1, wr, addr, wdata);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("%s_c%0d_en", name, k), 32'(mem_enable), 32'(k == 3));
         checkOutput($sformatf("%s_c%0d_wr", name, k), 32'(mem_wr), 32'((k == 3) && wr));
         checkOutput($sformatf("%s_c%0d_rv", name, k), 32'(resp_valid), 32'(k == 4));
         checkOutput($sformatf("%s_c%0d_rdy", name, k), 32'(req_ready), 32'd0);
         if (k == 3) begin
            checkOutput({name, "_addr"}, 32'(mem_addr), 32'(addr));
            checkOutput({name, "_wdata"}, 32'(mem_data_in), wr ? 32'(wdata) : 32'd0);
         end
         if (k == 4) begin
            checkOutput({name, "_rdata"}, 32'(resp_rdata), 32'(exp_rdata));
            checkOutput({name, "_err"}, 32'(resp_err), 32'd0);
         end
         nextCycle();
      end
      checkOutput({name, "_ready_post"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic seen_en;
      logic seen_rv;

      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      mem_init   = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      req_valid0 = 1'b0;
      req_wr0    = 1'b0;
      req_addr0  = 16'h0000;
      req_wdata0 = 16'h0000;

      #2;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rv", 32'(resp_valid), 32'd0);
      checkOutput("rst_err", 32'(resp_err), 32'd0);
      checkOutput("rst_rdata", 32'(resp_rdata), 32'd0);
      checkOutput("rst_en", 32'(mem_enable), 32'd0);
      checkOutput("rst_wr", 32'(mem_wr), 32'd0);
      checkOutput("rst_addr", 32'(mem_addr), 32'd0);
      checkOutput("rst_din", 32'(mem_data_in), 32'd0);

      @(posedge clk);
      #1;
      rst      = 1'b0;
      mem_init = 1'b0;

      runAligned("st10", 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
      runAligned("ld10", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

      // Misaligned load: error pulse in cycle 1, no memory strobe.
      applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      checkOutput("mis_rv", 32'(resp_valid), 32'd1);
      checkOutput("mis_err", 32'(resp_err), 32'd1);
      checkOutput("mis_rdata", 32'(resp_rdata), 32'd0);
      checkOutput("mis_en", 32'(mem_enable), 32'd0);
      nextCycle();
      checkOutput("mis_rv_after", 32'(resp_valid), 32'd0);
      checkOutput("mis_ready_after", 32'(req_ready), 32'd1);
      checkOutput("mis_en_after", 32'(mem_enable), 32'd0);

      // Store abandoned by a reset pulse during WAIT.
      applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      checkOutput("abort_wait_ready", 32'(req_ready), 32'd0);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("abort_async_ready", 32'(req_ready), 32'd1);
      #1;
      rst = 1'b0;
      seen_en = 1'b0;
      seen_rv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         nextCycle();
         seen_en = seen_en | mem_enable;
         seen_rv = seen_rv | resp_valid;
      end
      checkOutput("abort_no_en", 32'(seen_en), 32'd0);
      checkOutput("abort_no_rv", 32'(seen_rv), 32'd0);
      runAligned("ld20", 1'b0, 16'h0020, 16'h0000, 16'hA010);

      // Two stores with req_valid held high: ready low in cycles 1-4, high
      // again in cycle 5 where the second store is taken.
      applyStimulus(1'b1, 1'b1, 16'h0030, 16'h1111);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 16'h0032, 16'h2222);
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("held_c%0d_rdy", k), 32'(req_ready), 32'd0);
         if (k == 3) begin
            checkOutput("held_first_addr", 32'(mem_addr), 32'h0030);
            checkOutput("held_first_din", 32'(mem_data_in), 32'h1111);
         end
         nextCycle();
      end
      checkOutput("held_c5_rdy", 32'(req_ready), 32'd1);
      checkOutput("held_c5_en", 32'(mem_enable), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int k = 6; k <= 9; k++) begin
         checkOutput($sformatf("held_c%0d_en", k), 32'(mem_enable), 32'(k == 8));
         checkOutput($sformatf("held_c%0d_rv", k), 32'(resp_valid), 32'(k == 9));
         if (k == 8) begin
            checkOutput("held_second_addr", 32'(mem_addr), 32'h0032);
            checkOutput("held_second_din", 32'(mem_data_in), 32'h2222);
         end
         nextCycle();
      end
      runAligned("ld30", 1'b0, 16'h0030, 16'h0000, 16'h1111);
      runAligned("ld32", 1'b0, 16'h0032, 16'h0000, 16'h2222);

      // LATENCY=0 instance: ACCESS in cycle 1, RESP in cycle 2.
      checkOutput("l0_ready_pre", 32'(req_ready0), 32'd1);
      req_valid0 = 1'b1;
      req_wr0    = 1'b0;
      req_addr0  = 16'h0002;
      nextCycle();
      req_valid0 = 1'b0;
      req_addr0  = 16'h0000;
      checkOutput("l0_c1_en", 32'(mem_enable0), 32'd1);
      checkOutput("l0_c1_wr", 32'(mem_wr0), 32'd0);
      checkOutput("l0_c1_addr", 32'(mem_addr0), 32'h0002);
      checkOutput("l0_c1_rv", 32'(resp_valid0), 32'd0);
      nextCycle();
      checkOutput("l0_c2_rv", 32'(resp_valid0), 32'd1);
      checkOutput("l0_c2_rdata", 32'(resp_rdata0), 32'h5A58);
      checkOutput("l0_c2_err", 32'(resp_err0), 32'd0);
      checkOutput("l0_c2_en", 32'(mem_enable0), 32'd0);
      nextCycle();
      checkOutput("l0_c3_ready", 32'(req_ready0), 32'd1);
      checkOutput("l0_c3_rv", 32'(resp_valid0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
